fetch_sequencer: RTL and testbench

//  Next-address generator and fetch handshake master that drives the PC register's load interface (ld, inAddress).

---
 rtl/fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Next-address generator and instruction-fetch handshake master.
//                Issues the current PC to instruction memory with a req/ack
//                handshake. On the ack cycle it selects the next PC from
//                return, call, taken jump or sequential (priority in that
//                order). It then pulses pc_ld for one cycle to load the PC
//                register. A return-address stack (RAS) backs call/ret.
//
//  Parameters  : AW        address width (matches the PC register)
//                DEPTH     RAS entries, power of two, >= 2
//                TRAP_VEC  redirect address on a RAS fault (RAS_TRAP_EN only)
//
//  Ports       : clk, rst (async, active-low)
//                start / halt           - run control
//                pc_cur                 - current PC register value
//                imem_req/addr/ack      - instruction memory handshake
//                jmp/cond/call/ret/target - decoder outputs, sampled on ack
//                pc_ld / pc_next        - PC register load interface
//                ras_err                - sticky RAS overflow/underflow flag
//                busy                   - high whenever not IDLE
//
//  Config      : define RAS_TRAP_EN to redirect RAS faults to TRAP_VEC
//                (default: overflow drops the push and still jumps;
//                 underflow falls through sequentially)
//
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                AW       = 13,
    parameter int                DEPTH    = 8,
    parameter logic [AW-1:0]     TRAP_VEC = AW'(13'h1F00)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          halt,
    input  logic [AW-1:0] pc_cur,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic          jmp,
    input  logic          cond,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] target,
    output logic          pc_ld,
    output logic [AW-1:0] pc_next,
    output logic          ras_err,
    output logic          busy
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;           // sp counts 0..DEPTH inclusive

    localparam logic [SPW-1:0] c_SP_FULL = SPW'(DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FETCH  = 2'd1;
    localparam logic [1:0] c_UPDATE = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [AW-1:0]  r_pc_next;
    logic [AW-1:0]  w_pc_next_nxt;
    logic [SPW-1:0] r_sp;
    logic [SPW-1:0] w_sp_nxt;
    logic           r_ras_err;
    logic           w_ras_err_nxt;
    logic           w_push;

    logic [AW-1:0]  r_ras [DEPTH];

    logic [AW-1:0]  w_seq;
    logic [SPW-1:0] w_sp_m1;
    logic           w_empty;
    logic           w_full;

    assign w_seq   = pc_cur + AW'(1);
    assign w_sp_m1 = r_sp - SPW'(1);
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == c_SP_FULL);

`ifndef RAS_TRAP_EN
    // TRAP_VEC only matters in the trapping build.
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_VEC;
`endif

    // Outputs decoded straight from state so that an asynchronous reset
    // removes imem_req/pc_ld/busy in the same instant, with no extra edge.
    assign imem_req  = (r_state == c_FETCH);
    assign pc_ld     = (r_state == c_UPDATE);
    assign busy      = (r_state != c_IDLE);
    assign imem_addr = pc_cur;
    assign pc_next   = r_pc_next;
    assign ras_err   = r_ras_err;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_next_nxt = r_pc_next;
        w_sp_nxt      = r_sp;
        w_ras_err_nxt = r_ras_err;
        w_push        = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_FETCH;
                end
            end

            c_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = c_UPDATE;
                    if (ret) begin
                        if (w_empty) begin
                            w_ras_err_nxt = 1'b1;
`ifdef RAS_TRAP_EN
                            w_pc_next_nxt = TRAP_VEC;
`else
                            w_pc_next_nxt = w_seq;
`endif
                        end else begin
                            w_sp_nxt      = w_sp_m1;
                            w_pc_next_nxt = r_ras[w_sp_m1[IW-1:0]];
                        end
                    end else if (call) begin
                        if (w_full) begin
                            w_ras_err_nxt = 1'b1;
`ifdef RAS_TRAP_EN
                            w_pc_next_nxt = TRAP_VEC;
`else
                            w_pc_next_nxt = target;
`endif
                        end else begin
                            w_push        = 1'b1;
                            w_sp_nxt      = r_sp + SPW'(1);
                            w_pc_next_nxt = target;
                        end
                    end else if (jmp && cond) begin
                        w_pc_next_nxt = target;
                    end else begin
                        w_pc_next_nxt = w_seq;
                    end
                end
            end

            c_UPDATE: begin
                w_state_nxt = halt ? c_IDLE : c_FETCH;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_pc_next <= '0;
            r_sp      <= '0;
            r_ras_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc_next <= w_pc_next_nxt;
            r_sp      <= w_sp_nxt;
            r_ras_err <= w_ras_err_nxt;
        end
    end

    // Stack storage needs no reset: entries are only read below sp.
    // w_push is low during reset because r_state is then IDLE.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_sp[IW-1:0]] <= w_seq;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer. The bench
//                plays the PC register and instruction memory. Inputs are
//                driven and outputs checked on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic [12:0] pc_cur;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        imem_ack;
    logic        jmp;
    logic        cond;
    logic        call;
    logic        ret;
    logic [12:0] target;
    logic        pc_ld;
    logic [12:0] pc_next;
    logic        ras_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.AW(13), .DEPTH(8), .TRAP_VEC(13'h1F00)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt      (halt),
        .pc_cur    (pc_cur),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .jmp       (jmp),
        .cond      (cond),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .pc_ld     (pc_ld),
        .pc_next   (pc_next),
        .ras_err   (ras_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch transaction: wait for req, check address, ack after dly
    // cycles with the given decoder inputs, check the load pulse, then
    // apply the load to the modelled PC register.
    task automatic do_fetch(input string tag, input logic [12:0] pc,
                            input logic j, input logic c, input logic ca,
                            input logic r, input logic h,
                            input logic [12:0] tgt, input logic [12:0] exp,
                            input int dly);
        pc_cur = pc;
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
        check({tag, ":req"}, {31'd0, imem_req}, 32'd1);
        check({tag, ":addr"}, {19'd0, imem_addr}, {19'd0, pc});
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check({tag, ":req_hold"}, {31'd0, imem_req}, 32'd1);
        end
        jmp = j; cond = c; call = ca; ret = r; target = tgt; halt = h;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; jmp = 1'b0; cond = 1'b0; call = 1'b0; ret = 1'b0;
        target = 13'h0AAA;
        check({tag, ":ld"}, {31'd0, pc_ld}, 32'd1);
        check({tag, ":next"}, {19'd0, pc_next}, {19'd0, exp});
        check({tag, ":req_upd"}, {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        halt = 1'b0;
        check({tag, ":ld_once"}, {31'd0, pc_ld}, 32'd0);
        check({tag, ":req_after"}, {31'd0, imem_req}, {31'd0, !h});
        check({tag, ":busy_after"}, {31'd0, busy}, {31'd0, !h});
        pc_cur = exp;
    endtask

    logic [12:0] exp_v;

    initial begin
        rst = 1'b0; start = 1'b0; halt = 1'b0; pc_cur = 13'h0;
        imem_ack = 1'b0; jmp = 1'b0; cond = 1'b0; call = 1'b0; ret = 1'b0;
        target = 13'h0;

        // Reset state
        #12;
        check("rst:req",  {31'd0, imem_req}, 32'd0);
        check("rst:ld",   {31'd0, pc_ld},    32'd0);
        check("rst:next", {19'd0, pc_next},  32'd0);
        check("rst:err",  {31'd0, ras_err},  32'd0);
        check("rst:busy", {31'd0, busy},     32'd0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("idle:busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start:busy", {31'd0, busy}, 32'd1);

        // 1: first fetch at 0, ack after 2 cycles
        do_fetch("t1", 13'h000, 0, 0, 0, 0, 0, 13'h000, 13'h001, 2);
        check("t1:next_addr", {19'd0, imem_addr}, 32'h001);

        // 2: taken and not-taken jump
        do_fetch("t2a", 13'h03F, 1, 1, 0, 0, 0, 13'h07F, 13'h07F, 0);
        do_fetch("t2b", 13'h03F, 1, 0, 0, 0, 0, 13'h07F, 13'h040, 0);

        // 3: call then return
        do_fetch("t3c", 13'h010, 0, 0, 1, 0, 0, 13'h100, 13'h100, 0);
        do_fetch("t3r", 13'h105, 0, 0, 0, 1, 0, 13'h000, 13'h011, 0);
        check("t3:err", {31'd0, ras_err}, 32'd0);

        // 4: sequential wrap
        do_fetch("t4", 13'h1FFF, 0, 0, 0, 0, 0, 13'h000, 13'h0000, 0);

        // ret beats call when both asserted
        do_fetch("pri_c", 13'h200, 0, 0, 1, 0, 0, 13'h300, 13'h300, 0);
        do_fetch("pri_cr", 13'h305, 1, 1, 1, 1, 0, 13'h400, 13'h201, 0);
        check("pri:err", {31'd0, ras_err}, 32'd0);

        // 5: nine calls, then nine returns (stack empty on entry)
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_v = 13'h800 + 13'(i);
            else begin
`ifdef RAS_TRAP_EN
                exp_v = 13'h1F00;
`else
                exp_v = 13'h808;
`endif
            end
            do_fetch($sformatf("t5c%0d", i), 13'h020 + 13'(i), 0, 0, 1, 0, 0,
                     13'h800 + 13'(i), exp_v, 0);
            check($sformatf("t5c%0d:err", i), {31'd0, ras_err}, {31'd0, (i == 8)});
        end
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_v = 13'h028 - 13'(k);
            else begin
`ifdef RAS_TRAP_EN
                exp_v = 13'h1F00;
`else
                exp_v = 13'h909;
`endif
            end
            do_fetch($sformatf("t5r%0d", k), 13'h900 + 13'(k), 0, 0, 0, 1, 0,
                     13'h000, exp_v, 0);
        end
        check("t5:err_sticky", {31'd0, ras_err}, 32'd1);

        // 6: halt during UPDATE returns to IDLE
        do_fetch("t6h", 13'h050, 0, 0, 0, 0, 1, 13'h000, 13'h051, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6h:idle_req", {31'd0, imem_req}, 32'd0);
        end

        // 6: asynchronous reset in the middle of a fetch
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("t6r:req_pre", {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("t6r:req",  {31'd0, imem_req}, 32'd0);
        check("t6r:busy", {31'd0, busy},     32'd0);
        check("t6r:ld",   {31'd0, pc_ld},    32'd0);
        check("t6r:err",  {31'd0, ras_err},  32'd0);
        check("t6r:next", {19'd0, pc_next},  32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6r:idle_busy", {31'd0, busy},  32'd0);
            check("t6r:idle_ld",   {31'd0, pc_ld}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
